// File: rtl/cam_bbox_overlay.sv
// cam_bbox_overlay
// Tracks the bounding box and set-pixel count of the thresholded region in each
// frame, latches the result at the next vsync, and draws the previous frame's
// box outline onto the RGB565 video with one cycle of latency.
// Optional build macro: BBOX_CROSSHAIR_EN also draws the box centre row/column.

module cam_bbox_overlay #(
  parameter int unsigned X_W       = 11,
  parameter int unsigned Y_W       = 10,
  parameter int unsigned MIN_PIX   = 16,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [15:0]    in_data,
  input  logic           thr_data,
  input  logic           thr_de,
  input  logic           thr_hs,
  input  logic           thr_vs,
  output logic [15:0]    out_data,
  output logic           out_de,
  output logic           out_hs,
  output logic           out_vs,
  output logic           box_valid,
  output logic [X_W-1:0] box_x_min,
  output logic [X_W-1:0] box_x_max,
  output logic [Y_W-1:0] box_y_min,
  output logic [Y_W-1:0] box_y_max,
  output logic [19:0]    pix_cnt
);

  localparam logic [X_W-1:0] XMax   = '1;
  localparam logic [X_W-1:0] XOne   = X_W'(1);
  localparam logic [Y_W-1:0] YMax   = '1;
  localparam logic [Y_W-1:0] YOne   = Y_W'(1);
  localparam logic [19:0]    CntMax = '1;
  localparam logic [19:0]    CntOne = 20'd1;
  localparam logic [19:0]    MinPix = 20'(MIN_PIX);

  typedef enum logic [1:0] {
    StSync,
    StActive,
    StLatch
  } state_e;

  state_e state_q, state_d;

  logic de_q, vs_q;
  logic de_fall, vs_rise;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  logic acc_clear, acc_en, latch;

  logic [X_W-1:0] acc_x_min_q, acc_x_min_d;
  logic [X_W-1:0] acc_x_max_q, acc_x_max_d;
  logic [Y_W-1:0] acc_y_min_q, acc_y_min_d;
  logic [Y_W-1:0] acc_y_max_q, acc_y_max_d;
  logic [19:0]    acc_cnt_q, acc_cnt_d;

  logic           box_valid_d;
  logic [X_W-1:0] box_x_min_d, box_x_max_d;
  logic [Y_W-1:0] box_y_min_d, box_y_max_d;
  logic [19:0]    pix_cnt_d;

  logic        x_in, y_in, on_edge, on_cross, hit;
  logic [15:0] out_data_d;

  // Edge detection on the incoming data enable and vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      de_q <= thr_de;
      vs_q <= thr_vs;
    end
  end

  assign de_fall = de_q & ~thr_de;
  assign vs_rise = ~vs_q & thr_vs;

  // Pixel coordinate counters; x holds the current pixel's column during de.
  always_comb begin
    x_d = x_q;
    if (de_fall) begin
      x_d = '0;
    end else if (thr_de && (x_q != XMax)) begin
      x_d = x_q + XOne;
    end

    y_d = y_q;
    // vsync wins over a coincident end of line
    if (vs_rise) begin
      y_d = '0;
    end else if (de_fall && (y_q != YMax)) begin
      y_d = y_q + YOne;
    end
  end

  // Coordinate counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM next state and control strobes.
  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    latch     = 1'b0;
    unique case (state_q)
      StSync: begin
        // Partial frame after reset is discarded until a full frame starts.
        acc_clear = 1'b1;
        if (vs_rise) begin
          state_d = StActive;
        end
      end
      StActive: begin
        acc_en = thr_de & thr_data & ~thr_vs;
        if (vs_rise) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        latch     = 1'b1;
        acc_clear = 1'b1;
        state_d   = StActive;
      end
      default: begin
        state_d = StSync;
      end
    endcase
  end

  // Per-frame bounding box and count accumulation.
  always_comb begin
    acc_x_min_d = acc_x_min_q;
    acc_x_max_d = acc_x_max_q;
    acc_y_min_d = acc_y_min_q;
    acc_y_max_d = acc_y_max_q;
    acc_cnt_d   = acc_cnt_q;
    if (acc_clear) begin
      acc_x_min_d = '1;
      acc_x_max_d = '0;
      acc_y_min_d = '1;
      acc_y_max_d = '0;
      acc_cnt_d   = '0;
    end else if (acc_en) begin
      if (x_q < acc_x_min_q) begin
        acc_x_min_d = x_q;
      end
      if (x_q > acc_x_max_q) begin
        acc_x_max_d = x_q;
      end
      if (y_q < acc_y_min_q) begin
        acc_y_min_d = y_q;
      end
      if (y_q > acc_y_max_q) begin
        acc_y_max_d = y_q;
      end
      if (acc_cnt_q != CntMax) begin
        acc_cnt_d = acc_cnt_q + CntOne;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x_min_q <= '1;
      acc_x_max_q <= '0;
      acc_y_min_q <= '1;
      acc_y_max_q <= '0;
      acc_cnt_q   <= '0;
    end else begin
      acc_x_min_q <= acc_x_min_d;
      acc_x_max_q <= acc_x_max_d;
      acc_y_min_q <= acc_y_min_d;
      acc_y_max_q <= acc_y_max_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  // Commit of the finished frame; a too-small region keeps the old box.
  always_comb begin
    box_valid_d = box_valid;
    box_x_min_d = box_x_min;
    box_x_max_d = box_x_max;
    box_y_min_d = box_y_min;
    box_y_max_d = box_y_max;
    pix_cnt_d   = pix_cnt;
    if (latch) begin
      pix_cnt_d = acc_cnt_q;
      if (acc_cnt_q >= MinPix) begin
        box_valid_d = 1'b1;
        box_x_min_d = acc_x_min_q;
        box_x_max_d = acc_x_max_q;
        box_y_min_d = acc_y_min_q;
        box_y_max_d = acc_y_max_q;
      end else begin
        box_valid_d = 1'b0;
      end
    end
  end

  // Latched result registers, stable for the whole following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_valid <= 1'b0;
      box_x_min <= '0;
      box_x_max <= '0;
      box_y_min <= '0;
      box_y_max <= '0;
      pix_cnt   <= '0;
    end else begin
      box_valid <= box_valid_d;
      box_x_min <= box_x_min_d;
      box_x_max <= box_x_max_d;
      box_y_min <= box_y_min_d;
      box_y_max <= box_y_max_d;
      pix_cnt   <= pix_cnt_d;
    end
  end

  assign x_in = (x_q >= box_x_min) && (x_q <= box_x_max);
  assign y_in = (y_q >= box_y_min) && (y_q <= box_y_max);

  // Outline hit test against the previously latched box.
  always_comb begin
    on_edge = 1'b0;
    if (((x_q == box_x_min) || (x_q == box_x_max)) && y_in) begin
      on_edge = 1'b1;
    end
    if (((y_q == box_y_min) || (y_q == box_y_max)) && x_in) begin
      on_edge = 1'b1;
    end
  end

`ifdef BBOX_CROSSHAIR_EN
  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;
  logic [X_W-1:0] x_mid;
  logic [Y_W-1:0] y_mid;

  // Centre row/column; one extra bit keeps the sum from wrapping.
  always_comb begin
    x_sum    = {1'b0, box_x_min} + {1'b0, box_x_max};
    y_sum    = {1'b0, box_y_min} + {1'b0, box_y_max};
    x_mid    = x_sum[X_W:1];
    y_mid    = y_sum[Y_W:1];
    on_cross = ((x_q == x_mid) && y_in) || ((y_q == y_mid) && x_in);
  end
`else
  assign on_cross = 1'b0;
`endif

  assign hit = box_valid & thr_de & (on_edge | on_cross);

  // Output pixel selection: blanking forced to black.
  always_comb begin
    out_data_d = in_data;
    if (!thr_de) begin
      out_data_d = 16'h0000;
    end else if (hit) begin
      out_data_d = BOX_COLOR;
    end
  end

  // One-cycle output pipeline keeping data and syncs aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 16'h0000;
      out_de   <= 1'b0;
      out_hs   <= 1'b0;
      out_vs   <= 1'b0;
    end else begin
      out_data <= out_data_d;
      out_de   <= thr_de;
      out_hs   <= thr_hs;
      out_vs   <= thr_vs;
    end
  end

endmodule

// File: doc/cam_bbox_overlay.md
# cam_bbox_overlay

Consumer of the 1-bit thresholded pixel stream (`thr_data/thr_de/thr_hs/thr_vs`) from the camera threshold stage. It tracks the bounding box and set-pixel count of the region marked by `thr_data` over each frame and latches the result at frame end. It redraws the frame's RGB565 video with the previous frame's box outline before the LCD output stage.

## Interface
- `X_W`, 11: x counter and box x-coordinate width
- `Y_W`, 10: y counter and box y-coordinate width
- `MIN_PIX`, 16: minimum set pixels in a frame for the box to be declared valid
- `BOX_COLOR`, 16'hF800: RGB565 value drawn on the box outline
- `clk`  in  1  pixel clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_data`  in  16  RGB565 pixel, already aligned cycle-for-cycle with `thr_*`
- `thr_data`  in  1  binarised pixel, valid when `thr_de`=1
- `thr_de`, `thr_hs`, `thr_vs`  in  1 each  data enable, hsync, vsync (vsync active-high)
- `out_data`  out  16  RGB565 with overlay
- `out_de`, `out_hs`, `out_vs`  out  1 each  `thr_de/hs/vs` delayed 1 cycle
- `box_valid`  out  1  latched box valid for the last completed frame
- `box_x_min`, `box_x_max`  out  X_W  latched box x bounds, inclusive
- `box_y_min`, `box_y_max`  out  Y_W  latched box y bounds, inclusive
- `pix_cnt`  out  20  latched set-pixel count of the last completed frame

## Operation
- Edge detect: registered copies of `thr_de` and `thr_vs`.
  - `de_fall` = previous `de` is 1 and current `de` is 0.
  - `vs_rise` = previous `vs` is 0 and current `vs` is 1.
- x counter:
  - Increments on each `thr_de`=1 cycle and clears on `de_fall`.
  - Value during a pixel equals that pixel's column, starting at 0.
  - Saturates at 2^X_W-1.
- y counter:
  - Increments on `de_fall` and clears on `vs_rise`.
  - Saturates at 2^Y_W-1.
- FSM states:
  - SYNC: entered on reset. Ignores all data. Moves to ACTIVE on the first `vs_rise`.
  - ACTIVE: accumulates. On `vs_rise`, moves to LATCH.
  - LATCH: one cycle. Commits the results, clears the accumulators, returns to ACTIVE.
- Accumulation in ACTIVE, when `thr_de`=1, `thr_data`=1 and `thr_vs`=0:
  - Update `acc_x_min/x_max/y_min/y_max` with the current x/y.
  - Increment `acc_cnt`, saturating at 2^20-1.
- Accumulator clear values: mins all-ones, maxes 0, count 0.
- LATCH commit:
  - `pix_cnt` <= `acc_cnt`.
  - If `acc_cnt` >= MIN_PIX: box registers <= accumulators and `box_valid`=1.
  - Otherwise: `box_valid`=0 and the box registers keep their old values.
- Overlay, using the latched box (the previous frame). Pixel is on the outline when `box_valid`=1, `thr_de`=1, and either:
  - x equals `box_x_min` or `box_x_max`, with y in [`box_y_min`, `box_y_max`]; or
  - y equals `box_y_min` or `box_y_max`, with x in [`box_x_min`, `box_x_max`].
- `out_data`: BOX_COLOR on the outline, otherwise `in_data`. Forced to 16'h0000 when `thr_de`=0.
- Overlay is applied in all FSM states, including SYNC.

## Timing
- `out_data/out_de/out_hs/out_vs`: exactly 1 clk latency from the inputs. Sync relationships are preserved.
- `box_*`, `box_valid`, `pix_cnt` update on the clock edge ending the LATCH cycle, which is 2 cycles after the `thr_vs` rising sample. They are stable for the whole following frame.
- Reset values:
  - All outputs 0.
  - `box_valid`=0; the x/y counters are 0.
  - FSM in SYNC; accumulators at their clear values.
- Reset mid-frame: the partial frame is discarded. The first result comes from the first complete frame after the next `vs_rise`.
- Simultaneous events:
  - `vs_rise` and `de_fall` on the same cycle: y clears (vs wins).
  - `thr_de`=1 while `thr_vs`=1: output passes through but is not accumulated.
- Frame with zero set pixels: `pix_cnt`=0 and `box_valid`=0.
- Single set pixel with MIN_PIX=1: `x_min`=`x_max` and `y_min`=`y_max`.

## Configuration
- `BBOX_CROSSHAIR_EN` defined:
  - Also draws BOX_COLOR on column `(box_x_min+box_x_max)>>1` and row `(box_y_min+box_y_max)>>1`, inside the box only, when `box_valid`=1.
  - Sums are computed at X_W+1 and Y_W+1 bits so they do not wrap.
- `BBOX_CROSSHAIR_EN` undefined: outline only. No centre logic is synthesised.

## Test plan
- Reset, then frame 1 is 16x8 active with `thr_data`=1 at x 3..6 on rows 2..4, MIN_PIX=1 -> after LATCH: `box_x_min`=3, `box_x_max`=6, `box_y_min`=2, `box_y_max`=4, `pix_cnt`=12, `box_valid`=1.
- Frame 2 with `in_data`=16'h07E0 everywhere -> `out_data`=16'hF800 at (3,2) and (6,4); (4,3) outputs 16'h07E0; output is 1 cycle after input.
- Frame with no set pixels -> `box_valid`=0, `pix_cnt`=0, box coordinates keep 3/6/2/4; the next frame has no outline.
- MIN_PIX=16 with 12 set pixels -> `box_valid`=0, `pix_cnt`=12.
- Assert `rst_n`=0 mid-frame, then release -> all outputs 0; the next `vs_rise` only leaves SYNC; the first valid latch comes at the end of the following frame.
- With `BBOX_CROSSHAIR_EN` and box 3..6 x 2..4 -> column 4 on rows 2..4 and row 3 on x 3..6 output 16'hF800.
